// File: rtl/me_pkg.sv
// me_pkg: shared types and constants for the memory-access pipeline stage.
package me_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int ACK_TIMEOUT_DEF = 16;
endpackage

// File: rtl/me_load_align.sv
// me_load_align: picks the addressed byte/half out of a read word and extends it.
module me_load_align
  import me_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata_i[{addr_i, 3'b000} +: 8];
  assign h = rdata_i[{addr_i[1], 4'b0000} +: 16];
  assign data_o = size_i == SZ_BYTE ? {{24{~unsigned_i & b[7]}}, b}
                : size_i == SZ_HALF ? {{16{~unsigned_i & h[15]}}, h}
                : rdata_i;
endmodule

// File: rtl/me_stage.sv
// me_stage: memory stage issuing one data-bus access at a time, stalling the
// pipeline until ack, with misalignment and ack-timeout fault pulses.
module me_stage
  import me_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] val_out,
  input  logic        reg_w,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] wb_val,
  output logic        wb_reg_w,
  output logic        misalign,
  output logic        bus_err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, wdata_d, ld_data, wb_val_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, sz;
  logic        we_q, uns_q, access, aligned, start, stall_c;
  logic        wb_reg_w_d, misalign_d, bus_err_d;
  me_load_align u_align (
    .rdata_i    (dmem_rdata),
    .addr_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );
  assign sz      = mem_size == 2'b11 ? SZ_WORD : mem_size;
  assign access  = mem_r | mem_w;
  assign aligned = sz == SZ_BYTE || (sz == SZ_HALF ? !mem_addr[0] : mem_addr[1:0] == 2'b00);
  assign start   = state_q == IDLE && access && aligned;
  assign be_d    = sz == SZ_BYTE ? 4'b0001 << mem_addr[1:0] : sz == SZ_HALF ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_d = sz == SZ_BYTE ? {4{mem_data[7:0]}} : sz == SZ_HALF ? {2{mem_data[15:0]}} : mem_data;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_val_d   = wb_val;
    wb_reg_w_d = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_c    = 1'b0;
    if (state_q == IDLE) begin
      wb_val_d   = val_out;
      wb_reg_w_d = reg_w && !access;
      misalign_d = access && !aligned;
      stall_c    = start;
      state_d    = start ? BUSY : IDLE;
      cnt_d      = '0;
    end else if (dmem_ack) begin
      state_d    = IDLE;
      wb_reg_w_d = reg_w && !we_q;
      wb_val_d   = we_q ? wb_val : ld_data;
    end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
      // give up: release the pipeline and flag the fault instead of writing back
      state_d   = IDLE;
      bus_err_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      stall_c = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      wb_val   <= '0;
      wb_reg_w <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_val   <= wb_val_d;
      wb_reg_w <= wb_reg_w_d;
      misalign <= misalign_d;
      bus_err  <= bus_err_d;
      if (start) begin
        addr_q  <= mem_addr;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        size_q  <= sz;
        we_q    <= mem_w;
        uns_q   <= mem_unsigned;
      end
    end
  end
  assign dmem_req   = state_q == BUSY;
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? be_q : '0;
  assign dmem_wdata = dmem_req ? wdata_q : '0;
  assign stall      = rst_n & stall_c;
endmodule

// File: tb/tb_me_stage.sv
// tb_me_stage: directed stimulus against a transaction-level model of the memory stage.
module tb_me_stage;
  localparam int T = 16;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] val_out = '0, mem_addr = '0, mem_data = '0, dmem_rdata = '0;
  logic        reg_w = 1'b0, mem_r = 1'b0, mem_w = 1'b0, mem_unsigned = 1'b0, dmem_ack = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        dmem_req, dmem_we, stall, wb_reg_w, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_val;
  logic [3:0]  dmem_be;
  int n_vec = 0, n_err = 0;

  me_stage #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .val_out(val_out), .reg_w(reg_w), .mem_r(mem_r), .mem_w(mem_w),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_val(wb_val), .wb_reg_w(wb_reg_w), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] rd, input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v, m;
    int bits;
    bits = 8 * nbytes(s);
    v = rd >> (8 * (a % 4));
    if (bits == 32) return v;
    m = (32'd1 << bits) - 1;
    v &= m;
    if (!u && v[bits-1]) v |= ~m;
    return v;
  endfunction

  // model state: one outstanding transaction plus the expected registered outputs
  bit          m_busy, m_we, m_uns, e_rw, e_mis, e_berr, e_valid;
  int          m_cnt;
  logic [31:0] m_addr, m_data, e_val;
  logic [1:0]  m_size;

  always @(negedge clk) begin
    logic [1:0] s;
    int nb;
    if (!rst_n) begin
      chk("rst_stall", stall, 0); chk("rst_req", dmem_req, 0); chk("rst_wb_val", wb_val, 0);
      chk("rst_wb_reg_w", wb_reg_w, 0); chk("rst_misalign", misalign, 0); chk("rst_bus_err", bus_err, 0);
      m_busy = 0; m_cnt = 0; e_rw = 0; e_mis = 0; e_berr = 0; e_val = 0; e_valid = 1;
    end else begin
      chk("wb_reg_w", wb_reg_w, e_rw); chk("misalign", misalign, e_mis); chk("bus_err", bus_err, e_berr);
      if (e_valid) chk("wb_val", wb_val, e_val);
      s = mem_size == 2'd3 ? 2'd2 : mem_size;
      nb = nbytes(s);
      if (m_busy) begin
        chk("dmem_req", dmem_req, 1);
        chk("dmem_addr", dmem_addr, m_addr & ~32'd3);
        chk("dmem_we", dmem_we, m_we);
        chk("dmem_be", dmem_be, ((32'd1 << nbytes(m_size)) - 1) << (m_addr % 4));
        chk("dmem_wdata", dmem_wdata, m_size == 0 ? m_data[7:0] * 32'h01010101 :
                                      m_size == 1 ? m_data[15:0] * 32'h00010001 : m_data);
        chk("stall_busy", stall, !dmem_ack && m_cnt != T - 1);
        e_mis = 0; e_berr = 0;
        if (dmem_ack) begin
          m_busy = 0;
          e_rw = reg_w && !m_we;
          if (!m_we) begin e_val = load_val(dmem_rdata, m_addr, m_size, m_uns); e_valid = 1; end
        end else if (m_cnt == T - 1) begin
          m_busy = 0; e_berr = 1; e_rw = 0;
        end else m_cnt++;
      end else begin
        chk("dmem_req_idle", dmem_req, 0);
        chk("stall_idle", stall, (mem_r || mem_w) && (mem_addr % nb == 0));
        e_mis = 0; e_berr = 0;
        if (!(mem_r || mem_w)) begin
          e_val = val_out; e_valid = 1; e_rw = reg_w;
        end else if (mem_addr % nb == 0) begin
          m_busy = 1; m_cnt = 0; m_addr = mem_addr; m_we = mem_w; m_size = s;
          m_uns = mem_unsigned; m_data = mem_data; e_rw = 0; e_valid = 0;
        end else begin
          e_mis = 1; e_rw = 0; e_valid = 0;
        end
      end
    end
  end

  task automatic alu(input logic [31:0] v, input logic rw);
    @(posedge clk); #1;
    val_out = v; reg_w = rw; mem_r = 0; mem_w = 0;
  endtask

  task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic u, input int dly, input logic [31:0] rd,
                      output int nstall, output int nreq);
    nstall = 0; nreq = 0;
    @(posedge clk); #1;
    mem_r = r; mem_w = w; mem_addr = a; mem_data = d; mem_size = sz; mem_unsigned = u; reg_w = r & ~w;
    for (int i = 0; i < dly + 2; i++) begin
      if (i == dly + 1) begin dmem_ack = 1; dmem_rdata = rd; end
      @(negedge clk);
      nstall += int'(stall); nreq += int'(dmem_req);
      @(posedge clk); #1;
    end
    dmem_ack = 0; mem_r = 0; mem_w = 0; reg_w = 0;
  endtask

  initial begin
    int ns, nr;
    bit done;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    alu(32'h11, 1);
    alu(32'h22, 0);
    // ack while idle must be ignored
    @(posedge clk); #1 dmem_ack = 1; val_out = 32'h33; reg_w = 1;
    @(posedge clk); #1 dmem_ack = 0;
    @(negedge clk); chk("idle_ack_wb", wb_val, 32'h33);

    xfer(1, 0, 32'h100, 0, 2'b10, 0, 0, 32'hDEADBEEF, ns, nr);
    @(negedge clk);
    chk("w_load_val", wb_val, 32'hDEADBEEF); chk("w_load_rw", wb_reg_w, 1);
    chk("w_load_stall_cycles", ns, 1); chk("w_load_req_cycles", nr, 1);

    xfer(1, 0, 32'h103, 0, 2'b00, 0, 1, 32'h80112233, ns, nr);
    @(negedge clk); chk("b_load_signed", wb_val, 32'hFFFFFF80);
    xfer(1, 0, 32'h103, 0, 2'b00, 1, 0, 32'h80112233, ns, nr);
    @(negedge clk); chk("b_load_unsigned", wb_val, 32'h00000080);
    xfer(1, 0, 32'h102, 0, 2'b01, 0, 0, 32'h80011234, ns, nr);
    @(negedge clk); chk("h_load_signed", wb_val, 32'hFFFF8001);

    @(posedge clk); #1;
    mem_w = 1; mem_addr = 32'h202; mem_data = 32'h0000ABCD; mem_size = 2'b01; reg_w = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ack = 1;
      @(negedge clk);
      if (i > 0) begin chk("h_store_be", dmem_be, 4'b1100); chk("h_store_wdata", dmem_wdata, 32'hABCDABCD); end
      @(posedge clk); #1;
    end
    dmem_ack = 0; mem_w = 0;
    @(negedge clk); chk("h_store_rw", wb_reg_w, 0);

    xfer(1, 1, 32'h301, 32'h0000005A, 2'b00, 0, 0, 32'hFFFFFFFF, ns, nr);
    xfer(1, 0, 32'h400, 0, 2'b11, 0, 2, 32'h12345678, ns, nr);
    @(negedge clk); chk("size11_word", wb_val, 32'h12345678);

    @(posedge clk); #1 mem_r = 1; mem_addr = 32'h101; mem_size = 2'b10; reg_w = 1;
    @(negedge clk); chk("mis_stall", stall, 0); chk("mis_req", dmem_req, 0);
    @(posedge clk); #1 mem_r = 0;
    @(negedge clk); chk("mis_pulse", misalign, 1);
    @(negedge clk); chk("mis_pulse_end", misalign, 0);

    xfer(1, 0, 32'h500, 0, 2'b10, 0, T - 1, 32'hCAFEF00D, ns, nr);
    @(negedge clk);
    chk("late_ack_berr", bus_err, 0); chk("late_ack_val", wb_val, 32'hCAFEF00D); chk("late_ack_req_cycles", nr, T);

    @(posedge clk); #1 mem_r = 1; mem_addr = 32'h600; mem_size = 2'b10; reg_w = 1;
    nr = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      nr += int'(dmem_req);
      done = dmem_req && !stall;
      @(posedge clk); #1;
    end
    mem_r = 0;
    if (!done) chk("timeout_seen", 0, 1);
    @(negedge clk); chk("timeout_berr", bus_err, 1); chk("timeout_req_cycles", nr, T); chk("timeout_rw", wb_reg_w, 0);

    @(posedge clk); #1 mem_r = 1; mem_addr = 32'h700; mem_size = 2'b10; reg_w = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("rst_busy_req", dmem_req, 0); chk("rst_busy_stall", stall, 0);
    mem_r = 0;
    @(posedge clk); #1 rst_n = 1; val_out = 32'd5; reg_w = 1;
    @(posedge clk); #1 chk("post_rst_val", wb_val, 32'd5); chk("post_rst_rw", wb_reg_w, 1);
    alu(32'h77, 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/me_stage.md
ME_STAGE -- requirements
Module: me_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, maximum BUSY cycles to wait for dmem_ack before aborting.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 val_out  in  32  ALU result from EX/ME; write-back value for non-load ops.
REQ-005 reg_w  in  1  register write enable from EX/ME.
REQ-006 mem_r / mem_w  in  1 each  load / store request from EX/ME.
REQ-007 mem_addr  in  32  byte address; mem_data  in  32  store data.
REQ-008 mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word); mem_unsigned  in  1  zero-extend loads.
REQ-009 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (word-aligned); dmem_be  out  4; dmem_wdata  out  32.
REQ-010 dmem_ack  in  1; dmem_rdata  in  32  valid in the ack cycle.
REQ-011 stall  out  1  freeze IF..EX/ME when high.
REQ-012 wb_val  out  32; wb_reg_w  out  1  registered ME/WB outputs.
REQ-013 misalign  out  1; bus_err  out  1  single-cycle registered fault pulses.

Function
REQ-014 States: IDLE, BUSY; FSM leaves IDLE only for an aligned access.
REQ-015 Access = mem_r | mem_w; both high is a store, read ignored.
REQ-016 Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=00.
REQ-017 IDLE, no access: wb_val<=val_out, wb_reg_w<=reg_w each edge (latency 1), stall=0.
REQ-018 IDLE, aligned access: stall=1 combinationally; next edge latch addr/we/be/wdata/size, enter BUSY, counter<=0, wb_reg_w<=0.
REQ-019 IDLE, misaligned access: no request, misalign<=1 for one cycle, wb_reg_w<=0, stall=0.
REQ-020 BUSY: dmem_req=1 with dmem_addr/we/be/wdata stable until ack sampled; stall = !dmem_ack.
REQ-021 BUSY with dmem_ack: next edge -> IDLE; load: wb_val<=extended data, wb_reg_w<=reg_w; store: wb_reg_w<=0.
REQ-022 Upstream inputs are held stable while stall=1; block samples reg_w at ack.
REQ-023 BUSY without ack: counter increments; at counter==ACK_TIMEOUT-1 without ack -> IDLE, bus_err<=1 one cycle, wb_reg_w<=0, stall released that cycle.
REQ-024 Ack in the timeout cycle completes normally; no bus_err.
REQ-025 dmem_be: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
REQ-026 dmem_wdata: byte replicated x4, half replicated x2, word as-is.
REQ-027 Load extract: byte rdata[8*addr[1:0]+:8], half rdata[16*addr[1]+:16]; sign-extend unless mem_unsigned.
REQ-028 dmem_ack in IDLE is ignored.

Reset
REQ-029 rst_n low: state IDLE, counter 0, all outputs 0 (dmem_req, stall, wb_reg_w, misalign, bus_err, data buses).
REQ-030 Reset during BUSY drops dmem_req immediately; no write-back, no fault pulse.

Structure
REQ-031 Package me_pkg holds state enum, mem_size encodings and the ACK_TIMEOUT default.
REQ-032 Combinational sub-module me_load_align performs load extraction/extension; be/wdata generation stays inline.

Verification
REQ-033 Word load addr 0x100, ack on first BUSY cycle, rdata 0xDEADBEEF -> stall high 1 cycle, wb_val=0xDEADBEEF, wb_reg_w=1.
REQ-034 Signed byte load addr 0x103, rdata 0x80112233 -> be n/a, wb_val=0xFFFFFF80; with mem_unsigned -> 0x00000080.
REQ-035 Half store addr 0x202, data 0x0000ABCD, ack after 3 cycles -> dmem_be=1100, wdata=0xABCDABCD held 3 cycles, wb_reg_w=0.
REQ-036 Word load addr 0x101 -> no dmem_req, misalign pulse 1 cycle, stall 0.
REQ-037 No ack, ACK_TIMEOUT=16 -> dmem_req high 16 cycles, then bus_err pulse, IDLE.
REQ-038 rst_n low mid-BUSY -> dmem_req and stall 0 same cycle; after release, ALU op val_out=5 -> wb_val=5 next edge.
